// File: rtl/msrv32_pkg.sv
// Shared defaults and register-index types for the msrv32 register file slice.
package msrv32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/msrv32_pending_table.sv
// Pending-write scoreboard: per-register pending bits for in-flight loads,
// claim handshake, registered pending count and sticky WAW error flag.
module msrv32_pending_table #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_addr,
  output logic            claim_ready,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            flush,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pend_cnt,
  output logic            err_waw
);

  logic [NREG-1:0] pend_nxt;
  logic            claim_hit_clr;
  logic            claim_acc;
  logic            clr_eff;
  logic            inc;
  logic            dec;
  logic            waw;

  always_comb begin
    claim_hit_clr = clr_en && (clr_addr == claim_addr);
    // A load retiring into the claimed register this cycle frees it for the new claim.
    claim_ready   = !pending[claim_addr] || claim_hit_clr;
    claim_acc     = claim_valid && claim_ready && (claim_addr != '0);
    clr_eff       = clr_en && pending[clr_addr];
    // Clear and re-claim of the same register leaves the population unchanged.
    inc           = claim_acc && !(clr_eff && claim_hit_clr);
    dec           = clr_eff && !(claim_acc && claim_hit_clr);
    waw           = wa_en && (wa_addr != '0) && pending[wa_addr];

    pend_nxt = pending;
    if (clr_eff)   pend_nxt[clr_addr]   = 1'b0;
    if (claim_acc) pend_nxt[claim_addr] = 1'b1;
    if (flush)     pend_nxt             = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pending  <= '0;
      pend_cnt <= '0;
      err_waw  <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (flush) begin
        pend_cnt <= '0;
      end else if (inc && !dec) begin
        pend_cnt <= pend_cnt + (AW+1)'(1);
      end else if (dec && !inc) begin
        pend_cnt <= pend_cnt - (AW+1)'(1);
      end
      if (waw) err_waw <= 1'b1;
    end
  end

endmodule

// File: rtl/msrv32_regfile_scoreboard.sv
// Integer register file with NRD bypassed read ports, ALU and load write
// ports, and a pending-load scoreboard feeding operand busy to the stall logic.
module msrv32_regfile_scoreboard
  import msrv32_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int FWD_EN = 1
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [NRD*AW-1:0]   rs_addr_in,
  output logic [NRD*XLEN-1:0] rs_data_out,
  output logic [NRD-1:0]      rs_busy_out,
  input  logic                wa_en_in,
  input  logic [AW-1:0]       wa_addr_in,
  input  logic [XLEN-1:0]     wa_data_in,
  input  logic                wb_en_in,
  input  logic [AW-1:0]       wb_addr_in,
  input  logic [XLEN-1:0]     wb_data_in,
  input  logic                claim_valid_in,
  input  logic [AW-1:0]       claim_addr_in,
  output logic                claim_ready_out,
  input  logic                flush_in,
  output logic [AW:0]         pend_cnt_out,
  output logic                err_waw_out
);

  localparam logic FWD = (FWD_EN != 0);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic            wa_we;
  logic            wb_we;

  assign wa_we = wa_en_in && (wa_addr_in != '0);
  assign wb_we = wb_en_in && (wb_addr_in != '0);

  msrv32_pending_table #(
    .NREG (NREG),
    .AW   (AW)
  ) u_pending (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .claim_valid (claim_valid_in),
    .claim_addr  (claim_addr_in),
    .claim_ready (claim_ready_out),
    .clr_en      (wb_en_in),
    .clr_addr    (wb_addr_in),
    .flush       (flush_in),
    .wa_en       (wa_en_in),
    .wa_addr     (wa_addr_in),
    .pending     (pending),
    .pend_cnt    (pend_cnt_out),
    .err_waw     (err_waw_out)
  );

  // Port A is applied last so it wins a same-address collision with port B.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_we) regs[wb_addr_in] <= wb_data_in;
      if (wa_we) regs[wa_addr_in] <= wa_data_in;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            wa_hit;
    logic            wb_hit;
    logic [XLEN-1:0] data;

    assign addr   = rs_addr_in[k*AW +: AW];
    assign wa_hit = FWD && wa_en_in && (wa_addr_in == addr);
    assign wb_hit = FWD && wb_en_in && (wb_addr_in == addr);

    always_comb begin
      if (addr == '0)  data = '0;
      else if (wa_hit) data = wa_data_in;
      else if (wb_hit) data = wb_data_in;
      else             data = regs[addr];
    end

    assign rs_data_out[k*XLEN +: XLEN] = data;
    // A load landing this cycle satisfies the operand through the bypass.
    assign rs_busy_out[k] = pending[addr] && !wb_hit;
  end

endmodule

// File: tb/tb_msrv32_regfile_scoreboard.sv
// Directed bench for msrv32_regfile_scoreboard with a queued expectation scoreboard.
module tb_msrv32_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                reset_in;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                claim_valid;
  logic [AW-1:0]       claim_addr;
  logic                claim_ready;
  logic                flush;
  logic [AW:0]         pend_cnt;
  logic                err_waw;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  msrv32_regfile_scoreboard #(
    .XLEN   (32),
    .NREG   (32),
    .NRD    (2),
    .FWD_EN (1)
  ) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .rs_addr_in      (rs_addr),
    .rs_data_out     (rs_data),
    .rs_busy_out     (rs_busy),
    .wa_en_in        (wa_en),
    .wa_addr_in      (wa_addr),
    .wa_data_in      (wa_data),
    .wb_en_in        (wb_en),
    .wb_addr_in      (wb_addr),
    .wb_data_in      (wb_data),
    .claim_valid_in  (claim_valid),
    .claim_addr_in   (claim_addr),
    .claim_ready_out (claim_ready),
    .flush_in        (flush),
    .pend_cnt_out    (pend_cnt),
    .err_waw_out     (err_waw)
  );

  task automatic expv(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=<queued entry>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [31:0] rd(input int k);
    return rs_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] bz(input int k);
    return {31'd0, rs_busy[k]};
  endfunction

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rs_addr[k*AW +: AW] = a;
  endtask

  initial begin
    reset_in = 1'b1;
    rs_addr  = '0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_in = 1'b0;

    // 1: reset state on every read port
    next_cycle();
    for (int a = 1; a < 32; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a));
      expv("rst_rd0", 32'h0); expv("rst_rd1", 32'h0);
      expv("rst_bz0", 32'h0); expv("rst_bz1", 32'h0);
      #1;
      cmp(rd(0)); cmp(rd(1)); cmp(bz(0)); cmp(bz(1));
    end
    expv("rst_cnt", 32'h0); expv("rst_err", 32'h0);
    @(negedge clk);
    cmp(32'(pend_cnt)); cmp({31'd0, err_waw});

    // 2: port A write with same-cycle bypass
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    set_rd(0, 5'd5);
    expv("t2_fwd", 32'hDEADBEEF);
    @(negedge clk); cmp(rd(0));
    next_cycle();
    expv("t2_arr", 32'hDEADBEEF);
    @(negedge clk); cmp(rd(0));

    // 3: both ports hit x7, port A wins
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222;
    set_rd(1, 5'd7);
    expv("t3_fwd", 32'h1111);
    @(negedge clk); cmp(rd(1));
    next_cycle();
    expv("t3_arr", 32'h1111);
    @(negedge clk); cmp(rd(1));

    // 4: claim, re-claim blocked, clear with reclaim
    next_cycle();
    claim_valid = 1'b1; claim_addr = 5'd3;
    expv("t4_rdy1", 32'h1);
    @(negedge clk); cmp({31'd0, claim_ready});
    next_cycle();
    claim_valid = 1'b1; claim_addr = 5'd3;
    set_rd(0, 5'd3);
    expv("t4_rdy2", 32'h0); expv("t4_busy", 32'h1); expv("t4_cnt1", 32'h1);
    @(negedge clk); cmp({31'd0, claim_ready}); cmp(bz(0)); cmp(32'(pend_cnt));
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    claim_valid = 1'b1; claim_addr = 5'd3;
    expv("t4_rdy3", 32'h1); expv("t4_byp", 32'h55); expv("t4_bz0", 32'h0);
    @(negedge clk); cmp({31'd0, claim_ready}); cmp(rd(0)); cmp(bz(0));
    next_cycle();
    expv("t4_still", 32'h1); expv("t4_cnt2", 32'h1); expv("t4_arr", 32'h55);
    @(negedge clk); cmp(bz(0)); cmp(32'(pend_cnt)); cmp(rd(0));

    // 5: retire x3, claim three, flush over a claim
    next_cycle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h66;
    next_cycle();
    expv("t5_cnt0", 32'h0);
    @(negedge clk); cmp(32'(pend_cnt));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      claim_valid = 1'b1;
      claim_addr  = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
    end
    next_cycle();
    expv("t5_cnt3", 32'h3);
    @(negedge clk); cmp(32'(pend_cnt));
    next_cycle();
    flush = 1'b1; claim_valid = 1'b1; claim_addr = 5'd6;
    next_cycle();
    expv("t5_cntf", 32'h0);
    @(negedge clk); cmp(32'(pend_cnt));
    for (int i = 0; i < 4; i++) begin
      set_rd(0, (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : (i == 2) ? 5'd4 : 5'd6);
      expv("t5_bzf", 32'h0);
      #1; cmp(bz(0));
    end
    claim_addr = 5'd6;
    expv("t5_x6free", 32'h1);
    #1; cmp({31'd0, claim_ready});

    // 6: WAW on a pending register, then x0 is inert
    next_cycle();
    claim_valid = 1'b1; claim_addr = 5'd9;
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h7;
    next_cycle();
    set_rd(1, 5'd9);
    expv("t6_err", 32'h1); expv("t6_bz", 32'h1); expv("t6_arr", 32'h7);
    @(negedge clk); cmp({31'd0, err_waw}); cmp(bz(1)); cmp(rd(1));
    next_cycle();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hAAAA;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hBBBB;
    claim_valid = 1'b1; claim_addr = 5'd0;
    set_rd(0, 5'd0);
    expv("t6_x0rdy", 32'h1); expv("t6_x0rd", 32'h0); expv("t6_x0bz", 32'h0);
    @(negedge clk); cmp({31'd0, claim_ready}); cmp(rd(0)); cmp(bz(0));
    next_cycle();
    expv("t6_x0arr", 32'h0); expv("t6_cnt", 32'h1); expv("t6_errst", 32'h1);
    @(negedge clk); cmp(rd(0)); cmp(32'(pend_cnt)); cmp({31'd0, err_waw});

    // asynchronous reset in mid-cycle clears state without a clock edge
    next_cycle();
    set_rd(0, 5'd5);
    #2;
    reset_in = 1'b1;
    #1;
    expv("ar_cnt", 32'h0); expv("ar_err", 32'h0); expv("ar_x5", 32'h0);
    cmp(32'(pend_cnt)); cmp({31'd0, err_waw}); cmp(rd(0));
    @(negedge clk);
    reset_in = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
